// File: rtl/risc_controller_if.sv
// Control bus between the instruction sequencer and the datapath:
// opcode/zero flag flow in, single-cycle control strobes flow out.
interface risc_controller_if;
  // Plain level strobes, no valid/ready handshake: each strobe is a
  // combinational decode valid for the whole cycle and acted on at the next
  // rising edge.
  logic [2:0] opcode;
  logic       is_zero;
  logic       sel;
  logic       rd;
  logic       ld_ir;
  logic       halt;
  logic       inc_pc;
  logic       ld_ac;
  logic       ld_pc;
  logic       wr;
  logic       data_e;

  modport master (
    input  opcode, is_zero,
    output sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e
  );

  modport slave (
    output opcode, is_zero,
    input  sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e
  );
endinterface

// File: rtl/risc_controller.sv
// Simple RISC CPU sequencer: 8-phase instruction cycle plus a sticky HALTED
// state; every control strobe is a combinational decode of the state.
module risc_controller (
  input  logic                     clk,
  input  logic                     rst,
  risc_controller_if.master        bus,
  output logic [2:0]               dbg_phase,
  output logic                     dbg_halted
);

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  localparam logic [2:0] PH_INST_ADDR  = 3'd0;
  localparam logic [2:0] PH_INST_FETCH = 3'd1;
  localparam logic [2:0] PH_INST_LOAD  = 3'd2;
  localparam logic [2:0] PH_IDLE       = 3'd3;
  localparam logic [2:0] PH_OP_ADDR    = 3'd4;
  localparam logic [2:0] PH_OP_FETCH   = 3'd5;
  localparam logic [2:0] PH_ALU_OP     = 3'd6;
  localparam logic [2:0] PH_STORE      = 3'd7;

  logic [2:0] phase_q, phase_n;
  logic       halted_q, halted_n;
  logic       alu_op;

  assign alu_op = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                  (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= PH_INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_n;
      halted_q <= halted_n;
    end
  end

  // HLT freezes the phase register at OP_ADDR; only reset leaves HALTED.
  always_comb begin
    phase_n  = phase_q;
    halted_n = halted_q;
    if (!halted_q) begin
      if (phase_q == PH_OP_ADDR && bus.opcode == OP_HLT) begin
        halted_n = 1'b1;
      end else begin
        phase_n = phase_q + 3'd1;
      end
    end
  end

  always_comb begin
    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.halt   = 1'b0;
    bus.inc_pc = 1'b0;
    bus.ld_ac  = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.wr     = 1'b0;
    bus.data_e = 1'b0;
    if (halted_q) begin
      bus.halt = 1'b1;
    end else begin
      case (phase_q)
        PH_INST_ADDR: begin
          bus.sel = 1'b1;
        end
        PH_INST_FETCH: begin
          bus.sel = 1'b1;
          bus.rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          bus.sel   = 1'b1;
          bus.rd    = 1'b1;
          bus.ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          bus.inc_pc = 1'b1;
          bus.halt   = (bus.opcode == OP_HLT);
        end
        PH_OP_FETCH: begin
          bus.rd = alu_op;
        end
        PH_ALU_OP: begin
          // SKZ second increment: together with OP_ADDR this skips one word.
          bus.rd     = alu_op;
          bus.inc_pc = (bus.opcode == OP_SKZ) && bus.is_zero;
          bus.ld_pc  = (bus.opcode == OP_JMP);
          bus.data_e = (bus.opcode == OP_STO);
        end
        PH_STORE: begin
          bus.rd     = alu_op;
          bus.ld_ac  = alu_op;
          bus.ld_pc  = (bus.opcode == OP_JMP);
          bus.wr     = (bus.opcode == OP_STO);
          bus.data_e = (bus.opcode == OP_STO);
        end
        default: ;
      endcase
    end
  end

  assign dbg_phase  = phase_q;
  assign dbg_halted = halted_q;

endmodule

// File: tb/tb_risc_controller.sv
// Bench for risc_controller: directed scenarios then random instruction
// streams, every cycle compared against a rule-based reference model.
module tb_risc_controller;

  localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, AND_ = 3'b011;
  localparam logic [2:0] XOR_ = 3'b100, LDA = 3'b101, STO = 3'b110, JMP = 3'b111;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_phase;
  logic       dbg_halted;

  risc_controller_if bus();

  risc_controller dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dbg_phase  (dbg_phase),
    .dbg_halted (dbg_halted)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_rise = -1;
  logic prev_ld_ir = 1'b0;
  logic known = 1'b0;
  int   m_ph = 0;
  logic m_halted = 1'b0;

  // Output vector order: {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e}
  function automatic logic [8:0] exp_out(input int ph, input logic h,
                                         input logic [2:0] op, input logic z);
    logic aluop;
    logic sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
    if (h) return 9'b000100000;
    aluop  = (op == ADD) || (op == AND_) || (op == XOR_) || (op == LDA);
    sel    = (ph <= 3);
    rd     = (ph >= 1 && ph <= 3) || (ph >= 5 && aluop);
    ld_ir  = (ph == 2) || (ph == 3);
    halt   = (ph == 4) && (op == HLT);
    inc_pc = (ph == 4) || (ph == 6 && op == SKZ && z);
    ld_ac  = (ph == 7) && aluop;
    ld_pc  = (ph >= 6) && (op == JMP);
    wr     = (ph == 7) && (op == STO);
    data_e = (ph >= 6) && (op == STO);
    return {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e};
  endfunction

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%b exp=%b cycle=%0d model_phase=%0d model_halted=%0b",
               tag, got, exp, cyc, m_ph, m_halted);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic [2:0] op, input logic z, input logic r);
    logic [8:0] got;
    bus.opcode  = op;
    bus.is_zero = z;
    rst         = r;
    @(negedge clk);
    cyc++;
    got = {bus.sel, bus.rd, bus.ld_ir, bus.halt, bus.inc_pc,
           bus.ld_ac, bus.ld_pc, bus.wr, bus.data_e};
    if (known) begin
      check_eq("outputs", got, exp_out(m_ph, m_halted, op, z));
      check_eq("phase", {6'd0, dbg_phase}, 9'(m_ph));
      check_eq("halted", {8'd0, dbg_halted}, {8'd0, m_halted});
    end
    if (bus.ld_ir && !prev_ld_ir) begin
      if (last_rise >= 0) check_eq("period", 9'(cyc - last_rise), 9'd8);
      last_rise = cyc;
    end
    prev_ld_ir = bus.ld_ir;
    @(posedge clk);
    if (r) begin
      m_ph      = 0;
      m_halted  = 1'b0;
      known     = 1'b1;
      last_rise = -1;
    end else if (!m_halted) begin
      if (m_ph == 4 && op == HLT) m_halted = 1'b1;
      else m_ph = (m_ph + 1) % 8;
    end
    #1;
  endtask

  // One 8-cycle instruction slot; opcode is garbage while it is ignored and
  // is_zero is random except in phase 6.
  task automatic run_instr(input logic [2:0] op, input logic z6);
    for (int p = 0; p < 8; p++) begin
      cycle((p < 4) ? 3'($urandom_range(7)) : op,
            (p == 6) ? z6 : 1'($urandom_range(1)), 1'b0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] cur_op;
    int         halt_wait;
    rst = 1'b1;
    bus.opcode = ADD;
    bus.is_zero = 1'b0;

    // reset / fetch
    cycle(ADD, 1'b0, 1'b1);
    cycle(ADD, 1'b0, 1'b1);
    run_instr(ADD, 1'b0);
    // SKZ taken and not taken
    run_instr(SKZ, 1'b1);
    run_instr(SKZ, 1'b0);
    // STO vs JMP
    run_instr(STO, 1'b0);
    run_instr(JMP, 1'b1);
    // opcode sweep, HLT last
    for (int op = 1; op < 8; op++) run_instr(3'(op), 1'($urandom_range(1)));
    run_instr(HLT, 1'b0);
    for (int i = 0; i < 20; i++) cycle(3'(i % 8), 1'(i % 2), 1'b0);
    cycle(ADD, 1'b0, 1'b1);
    // reset during phase 6 of STO
    for (int p = 0; p < 6; p++) cycle((p < 4) ? ADD : STO, 1'b0, 1'b0);
    cycle(STO, 1'b0, 1'b1);
    run_instr(ADD, 1'b1);

    // random instruction stream with occasional HLT and mid-instruction reset
    cur_op = ADD;
    halt_wait = 0;
    for (int i = 0; i < 2500; i++) begin
      logic [2:0] op;
      logic       r;
      if (m_ph == 0 && !m_halted) begin
        cur_op = ($urandom_range(15) == 0) ? HLT : 3'($urandom_range(7, 1));
      end
      op = (m_halted || m_ph < 4) ? 3'($urandom_range(7)) : cur_op;
      if (m_halted) halt_wait++;
      r = ($urandom_range(63) == 0) || (halt_wait > 12);
      if (r) halt_wait = 0;
      cycle(op, 1'($urandom_range(1)), r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
